// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory port controller.
// Access sizes, FSM states, owner codes and the latched access bundle.
package dm_arbiter_pkg;

  localparam logic [1:0] DM_word     = 2'd0;
  localparam logic [1:0] DM_halfword = 2'd1;
  localparam logic [1:0] DM_byte     = 2'd2;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_REQ,
    DMA_WAIT,
    DMA_DONE
  } dma_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } xfer_t;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/dm_arbiter_store_align.sv
// CPU store lane steering: byte enables, replicated data
// and the alignment check for halfword/word accesses.
module dm_arbiter_store_align
  import dm_arbiter_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  // Decode access size into lanes; loads never assert enables.
  always_comb begin
    byteen    = 4'b1111;
    wdata_rep = wdata;
    misalign  = |addr;
    unique case (1'b1)
      (op == DM_byte): begin
        byteen    = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        misalign  = 1'b0;
      end
      (op == DM_halfword): begin
        byteen    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr[0];
      end
      default: ;
    endcase
    if (!we) byteen = 4'b0000;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port controller: CPU/debug round-robin
// arbitration and req/gnt/rvalid sequencing.
module dm_arbiter
  import dm_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  dma_state_t  state, state_n;
  owner_t      last_owner, last_owner_n;
  owner_t      sel;
  xfer_t       xfer, xfer_n;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;
  logic        mis, capture;
  logic [3:0]  sa_byteen;
  logic [31:0] sa_wdata;
  logic        sa_misalign;
  logic        in_req, in_done;

  dm_arbiter_store_align u_align (
    .op        (cpu_op),
    .addr      (cpu_addr[1:0]),
    .wdata     (cpu_wdata),
    .we        (cpu_we),
    .byteen    (sa_byteen),
    .wdata_rep (sa_wdata),
    .misalign  (sa_misalign)
  );

  // State, owner history, latched access and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= DMA_IDLE;
      last_owner  <= OWN_DBG;
      xfer        <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      xfer       <= xfer_n;
      if (capture) begin
        if (xfer.owner == OWN_CPU)
          cpu_rdata_q <= mem_rdata;
        else
          dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Arbitration, misalign rejection and handshake sequencing.
  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    xfer_n       = xfer;
    sel          = OWN_CPU;
    mis          = 1'b0;
    capture      = 1'b0;
    unique case (state)
      DMA_IDLE: begin
        if (cpu_req && dbg_req)
          sel = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else if (dbg_req)
          sel = OWN_DBG;
        if (reset && (cpu_req || dbg_req)) begin
          if (sel == OWN_CPU && sa_misalign) begin
            mis = 1'b1;
          end else begin
            state_n      = DMA_REQ;
            last_owner_n = sel;
            xfer_n.owner = sel;
            if (sel == OWN_CPU) begin
              xfer_n.we     = cpu_we;
              xfer_n.addr   = word_addr(cpu_addr);
              xfer_n.byteen = sa_byteen;
              xfer_n.wdata  = sa_wdata;
            end else begin
              xfer_n.we     = dbg_we;
              xfer_n.addr   = word_addr(dbg_addr);
              xfer_n.byteen = dbg_we ? 4'b1111 : 4'b0000;
              xfer_n.wdata  = dbg_wdata;
            end
          end
        end
      end
      DMA_REQ: begin
        if (mem_gnt) state_n = DMA_WAIT;
      end
      DMA_WAIT: begin
        if (mem_rvalid) begin
          state_n = DMA_DONE;
          capture = !xfer.we;
        end
      end
      DMA_DONE: begin
        state_n = DMA_IDLE;
      end
      default: state_n = DMA_IDLE;
    endcase
  end

  assign in_req  = (state == DMA_REQ);
  assign in_done = (state == DMA_DONE);

  assign cpu_misalign = mis;
  assign cpu_rvalid   = mis |
                        (in_done & (xfer.owner == OWN_CPU));
  assign cpu_rdata    = mis ? 32'd0 : cpu_rdata_q;
  assign cpu_stall    = reset & cpu_req & ~cpu_rvalid;

  assign dbg_done  = in_done & (xfer.owner == OWN_DBG);
  assign dbg_rdata = dbg_rdata_q;

  assign mem_req    = in_req;
  assign mem_we     = in_req & xfer.we;
  assign mem_addr   = in_req ? xfer.addr : 32'd0;
  assign mem_byteen = in_req ? xfer.byteen : 4'd0;
  assign mem_wdata  = in_req ? xfer.wdata : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level model checked
// every cycle plus directed scenarios with literal values.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [1:0]  cpu_op = DM_word;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_stall, cpu_rvalid, cpu_misalign;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 0, dbg_we = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic        dbg_done;
  logic [31:0] dbg_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;

  dm_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_op       (cpu_op),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .cpu_misalign (cpu_misalign),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_done     (dbg_done),
    .dbg_rdata    (dbg_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_byteen   (mem_byteen),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // memory responder
  int gnt_delay = 0, resp_delay = 0;
  int gcnt = 0, rcnt = 0;
  bit pend = 0;
  logic [31:0] rd_word = 0;
  logic [31:0] gnt_log[$];

  always @(posedge clk) begin
    #2;
    mem_gnt = 0;
    mem_rvalid = 0;
    if (!reset) begin
      gcnt = 0;
      pend = 0;
    end else begin
      if (pend) begin
        if (rcnt == resp_delay) begin
          mem_rvalid = 1;
          mem_rdata = rd_word;
          pend = 0;
        end else rcnt++;
      end
      if (mem_req) begin
        if (gcnt == gnt_delay) begin
          mem_gnt = 1;
          gcnt = 0;
          pend = 1;
          rcnt = 0;
          gnt_log.push_back(mem_addr);
        end else gcnt++;
      end
    end
  end

  // transaction-level reference model
  bit m_busy, m_gnt, m_resp, m_we, m_owner;
  bit m_last = 1;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_crd = 0, m_drd = 0;
  logic [3:0]  m_be;
  bit any, pick, mis, done, ecrv, edd, ereq;
  int sz;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rvalid", cpu_rvalid, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_misalign", cpu_misalign, 0);
      chk("rst_dbg_done", dbg_done, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_byteen, 0);
      chk("rst_mem_wd", mem_wdata, 0);
      m_busy = 0;
      m_gnt = 0;
      m_resp = 0;
      m_last = 1;
      m_crd = 0;
      m_drd = 0;
    end else begin
      any  = cpu_req || dbg_req;
      pick = (cpu_req && dbg_req) ? !m_last : dbg_req;
      sz   = (cpu_op == DM_byte) ? 1 :
             (cpu_op == DM_halfword) ? 2 : 4;
      mis  = !m_busy && cpu_req && !pick &&
             (int'(cpu_addr[1:0]) % sz != 0);
      done = m_busy && m_resp;
      ereq = m_busy && !m_gnt;
      ecrv = mis || (done && !m_owner);
      edd  = done && m_owner;
      chk("m_misalign", cpu_misalign, mis);
      chk("m_rvalid", cpu_rvalid, ecrv);
      chk("m_rdata", cpu_rdata, mis ? 32'd0 : m_crd);
      chk("m_stall", cpu_stall, cpu_req && !ecrv);
      chk("m_dbg_done", dbg_done, edd);
      chk("m_dbg_rdata", dbg_rdata, m_drd);
      chk("m_mem_req", mem_req, ereq);
      if (ereq) begin
        chk("m_mem_we", mem_we, m_we);
        chk("m_mem_addr", mem_addr, m_addr);
        chk("m_mem_be", mem_byteen, m_be);
        chk("m_mem_wd", mem_wdata, m_wd);
      end
      if (!m_busy) begin
        if (any && !mis) begin
          m_busy  = 1;
          m_gnt   = 0;
          m_resp  = 0;
          m_owner = pick;
          m_last  = pick;
          if (!pick) begin
            m_we   = cpu_we;
            m_addr = cpu_addr & ~32'd3;
            m_be   = cpu_we ? 4'(((1 << sz) - 1)
                     << cpu_addr[1:0]) : 4'd0;
            m_wd   = (sz == 1) ?
                     32'(cpu_wdata[7:0]) * 32'h01010101 :
                     (sz == 2) ?
                     32'(cpu_wdata[15:0]) * 32'h00010001 :
                     cpu_wdata;
          end else begin
            m_we   = dbg_we;
            m_addr = dbg_addr & ~32'd3;
            m_be   = dbg_we ? 4'hF : 4'h0;
            m_wd   = dbg_wdata;
          end
        end
      end else if (!m_gnt) begin
        if (mem_gnt) m_gnt = 1;
      end else if (!m_resp) begin
        if (mem_rvalid) begin
          m_resp = 1;
          if (!m_we) begin
            if (m_owner) m_drd = mem_rdata;
            else m_crd = mem_rdata;
          end
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // debug load, inputs changed after acceptance
    step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h13;
    rd_word = 32'hDEADBEEF;
    smp();
    chk("t1_c0_done", dbg_done, 0);
    chk("t1_c0_req", mem_req, 0);
    step();
    dbg_req = 0; dbg_addr = 32'hFFFF_FFF0;
    smp();
    chk("t1_c1_req", mem_req, 1);
    chk("t1_c1_addr", mem_addr, 32'h10);
    chk("t1_c1_be", mem_byteen, 4'b0000);
    step(); smp();
    chk("t1_c2_done", dbg_done, 0);
    step(); smp();
    chk("t1_c3_done", dbg_done, 1);
    chk("t1_c3_rdata", dbg_rdata, 32'hDEADBEEF);
    step(); smp();
    chk("t1_c4_done", dbg_done, 0);
    chk("t1_c4_hold", dbg_rdata, 32'hDEADBEEF);

    // CPU byte store
    step();
    cpu_req = 1; cpu_we = 1; cpu_op = DM_byte;
    cpu_addr = 32'h1006; cpu_wdata = 32'hA5;
    smp();
    chk("t2_c0_stall", cpu_stall, 1);
    step(); smp();
    chk("t2_c1_be", mem_byteen, 4'b0100);
    chk("t2_c1_wd", mem_wdata, 32'hA5A5A5A5);
    chk("t2_c1_we", mem_we, 1);
    chk("t2_c1_stall", cpu_stall, 1);
    step(); smp();
    chk("t2_c2_stall", cpu_stall, 1);
    step(); smp();
    chk("t2_c3_stall", cpu_stall, 0);
    chk("t2_c3_rvalid", cpu_rvalid, 1);
    step();
    cpu_req = 0; cpu_we = 0;

    // misaligned halfword load
    step();
    cpu_req = 1; cpu_op = DM_halfword;
    cpu_addr = 32'h2001;
    smp();
    chk("t3_misalign", cpu_misalign, 1);
    chk("t3_rvalid", cpu_rvalid, 1);
    chk("t3_stall", cpu_stall, 0);
    chk("t3_req", mem_req, 0);
    chk("t3_rdata", cpu_rdata, 0);
    step();
    cpu_req = 0;
    smp();
    chk("t3_c1_misalign", cpu_misalign, 0);
    chk("t3_c1_req", mem_req, 0);

    // both requesting from reset, slow grants
    step(); reset = 0;
    step(); reset = 1;
    gnt_delay = 2;
    rd_word = 32'h0BADF00D;
    gnt_log.delete();
    cpu_req = 1; cpu_we = 0; cpu_op = DM_word;
    cpu_addr = 32'h100;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200;
    dbg_wdata = 32'h55;
    for (int i = 0; i < 100 && gnt_log.size() < 4; i++)
      step();
    chk("t4_count", gnt_log.size(), 4);
    cpu_req = 0; dbg_req = 0;
    repeat (10) step();
    chk("t4_g0", gnt_log[0], 32'h100);
    chk("t4_g1", gnt_log[1], 32'h200);
    chk("t4_g2", gnt_log[2], 32'h100);
    chk("t4_g3", gnt_log[3], 32'h200);

    // reset during WAIT of a CPU store
    gnt_delay = 0; resp_delay = 3;
    step();
    cpu_req = 1; cpu_we = 1; cpu_op = DM_word;
    cpu_addr = 32'h300; cpu_wdata = 32'h12345678;
    step(); step(); step();
    reset = 0;
    #1;
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_stall", cpu_stall, 0);
    chk("t5_rst_rvalid", cpu_rvalid, 0);
    chk("t5_rst_rdata", cpu_rdata, 0);
    chk("t5_rst_dbg_rdata", dbg_rdata, 0);
    chk("t5_rst_we", mem_we, 0);
    cpu_we = 0; cpu_addr = 32'h304;
    resp_delay = 0; rd_word = 32'hCAFEF00D;
    step(); step();
    reset = 1;
    smp();
    chk("t5_c0_rvalid", cpu_rvalid, 0);
    step(); smp();
    chk("t5_c1_req", mem_req, 1);
    chk("t5_c1_addr", mem_addr, 32'h304);
    step(); smp();
    chk("t5_c2_stall", cpu_stall, 1);
    step(); smp();
    chk("t5_c3_rvalid", cpu_rvalid, 1);
    chk("t5_c3_rdata", cpu_rdata, 32'hCAFEF00D);
    chk("t5_c3_stall", cpu_stall, 0);
    step();
    cpu_req = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
